// File: rtl/rf_arbiter_pkg.sv
// rf_arbiter_pkg: shared widths and FSM encoding for the register-file arbiter
package rf_arbiter_pkg;
  localparam int DEF_AW = 3;
  localparam int DEF_DW = 4;
  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;
endpackage

// File: rtl/rf_arbiter_if.sv
// rf_arbiter_if: one client's request/grant/read-data channel
interface rf_arbiter_if
  import rf_arbiter_pkg::*;
#(parameter int AW = DEF_AW, parameter int DW = DEF_DW);
  logic req;
  logic we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic gnt;
  logic rvalid;
  logic [DW-1:0] rdata;
  modport master(output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/rf_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; on a tie the client not granted last wins
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic idx,
  output logic valid
);
  assign valid = req0 | req1;
  assign idx = (req0 & req1) ? ~last_gnt : req1;
endmodule

// File: rtl/rf_arbiter.sv
// rf_arbiter: serialises two clients' single-word accesses onto one register file
module rf_arbiter
  import rf_arbiter_pkg::*;
#(parameter int AW = DEF_AW, parameter int DW = DEF_DW) (
  input  logic clk,
  input  logic rst,
  rf_arbiter_if.slave c0,
  rf_arbiter_if.slave c1,
  output logic rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_wdata,
  input  logic [DW-1:0] rf_rdata
);
  state_t state, nxt;
  logic last_gnt, cur, idx, valid;
  logic lg_d, cur_d, we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d, rd0_d, rd1_d, rdata0, rdata1;
  logic [1:0] gnt, gnt_d, rvalid, rv_d;
  rr_arb2 u_arb (.req0(c0.req), .req1(c1.req), .last_gnt, .idx, .valid);
  always_comb begin
    nxt = state;
    lg_d = last_gnt;
    cur_d = cur;
    we_d = 1'b0;
    addr_d = rf_addr;
    wdata_d = rf_wdata;
    gnt_d = '0;
    rv_d = '0;
    rd0_d = rdata0;
    rd1_d = rdata1;
    if (state == ST_IDLE && valid) begin
      nxt = ST_ISSUE;
      lg_d = idx;
      cur_d = idx;
      we_d = idx ? c1.we : c0.we;
      addr_d = idx ? c1.addr : c0.addr;
      wdata_d = idx ? c1.wdata : c0.wdata;
      gnt_d = idx ? 2'b10 : 2'b01;
    end else if (state == ST_ISSUE) begin
      // rf_we low in ISSUE means the current operation is a read
      nxt = ST_IDLE;
      rv_d = rf_we ? 2'b00 : (cur ? 2'b10 : 2'b01);
      rd0_d = (!rf_we && !cur) ? rf_rdata : rdata0;
      rd1_d = (!rf_we && cur) ? rf_rdata : rdata1;
    end
  end
  always_ff @(posedge clk) state <= rst ? ST_IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
      cur <= 1'b0;
      rf_we <= 1'b0;
      rf_addr <= '0;
      rf_wdata <= '0;
      gnt <= '0;
      rvalid <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      last_gnt <= lg_d;
      cur <= cur_d;
      rf_we <= we_d;
      rf_addr <= addr_d;
      rf_wdata <= wdata_d;
      gnt <= gnt_d;
      rvalid <= rv_d;
      rdata0 <= rd0_d;
      rdata1 <= rd1_d;
    end
  end
  assign c0.gnt = gnt[0];
  assign c1.gnt = gnt[1];
  assign c0.rvalid = rvalid[0];
  assign c1.rvalid = rvalid[1];
  assign c0.rdata = rdata0;
  assign c1.rdata = rdata1;
endmodule

// File: tb/tb_rf_arbiter.sv
// tb_rf_arbiter: directed plus random stimulus against a transaction-level schedule model
module tb_rf_arbiter;
  localparam int NC = 4096;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rf_arbiter_if i0 ();
  rf_arbiter_if i1 ();
  logic rf_we;
  logic [2:0] rf_addr;
  logic [3:0] rf_wdata, rf_rdata;
  logic [3:0] mem [8] = '{default: 4'd0};
  rf_arbiter dut (.clk(clk), .rst(rst), .c0(i0), .c1(i1), .rf_we(rf_we), .rf_addr(rf_addr),
                  .rf_wdata(rf_wdata), .rf_rdata(rf_rdata));
  assign rf_rdata = mem[rf_addr];
  always @(posedge clk) if (rf_we) mem[rf_addr] <= rf_wdata;

  int n = 0, checks = 0, errors = 0;
  bit eg0 [NC], eg1 [NC], ewe [NC], ev0 [NC], ev1 [NC], rs0 [NC], rs1 [NC];
  logic [2:0] ea [NC];
  logic [3:0] evd0 [NC], evd1 [NC];
  logic [3:0] mm [8];
  logic [3:0] erd0, erd1;
  int gq[$], gn[$];
  logic [3:0] rq0[$], rq1[$];

  // schedule model: a grant at edge n means gnt after n, a free slot again at n+2,
  // and for reads the data (memory contents at grant time) after n+1
  initial begin
    bit last, w, we;
    int next_ok;
    logic [2:0] a;
    logic [3:0] d;
    for (int i = 0; i < 8; i++) mm[i] = 4'd0;
    erd0 = 4'd0;
    erd1 = 4'd0;
    last = 1'b1;
    next_ok = 0;
    forever begin
      @(posedge clk);
      n++;
      if (rst) begin
        ev0[n] = 0; ev1[n] = 0; rs0[n] = 0; rs1[n] = 0;
        erd0 = 4'd0; erd1 = 4'd0;
        last = 1'b1;
        next_ok = n + 1;
      end else if (n >= next_ok && (i0.req || i1.req)) begin
        w = (i0.req && i1.req) ? !last : i1.req;
        last = w;
        next_ok = n + 2;
        we = w ? i1.we : i0.we;
        a = w ? i1.addr : i0.addr;
        d = w ? i1.wdata : i0.wdata;
        if (w) eg1[n] = 1; else eg0[n] = 1;
        ewe[n] = we;
        ea[n] = a;
        if (we) mm[a] = d;
        else if (w) begin ev1[n+1] = 1; rs1[n+1] = 1; evd1[n+1] = mm[a]; end
        else begin ev0[n+1] = 1; rs0[n+1] = 1; evd0[n+1] = mm[a]; end
      end
      if (rs0[n]) erd0 = evd0[n];
      if (rs1[n]) erd1 = evd1[n];
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, n, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (n > 0) begin
      chk("gnt0", 8'(i0.gnt), 8'(eg0[n]));
      chk("gnt1", 8'(i1.gnt), 8'(eg1[n]));
      chk("rvalid0", 8'(i0.rvalid), 8'(ev0[n]));
      chk("rvalid1", 8'(i1.rvalid), 8'(ev1[n]));
      chk("rdata0", 8'(i0.rdata), 8'(erd0));
      chk("rdata1", 8'(i1.rdata), 8'(erd1));
      chk("rf_we", 8'(rf_we), 8'(ewe[n]));
      if (eg0[n] || eg1[n]) chk("rf_addr", 8'(rf_addr), 8'(ea[n]));
    end
  end

  initial forever begin
    @(negedge clk);
    if (i0.gnt) begin gq.push_back(0); gn.push_back(n); end
    if (i1.gnt) begin gq.push_back(1); gn.push_back(n); end
    if (i0.rvalid) rq0.push_back(i0.rdata);
    if (i1.rvalid) rq1.push_back(i1.rdata);
  end

  function automatic logic g(input int c);
    return c == 0 ? i0.gnt : i1.gnt;
  endfunction

  task automatic drive(input int c, input bit r, input bit we, input int a, input int d);
    if (c == 0) begin i0.req = r; i0.we = we; i0.addr = 3'(a); i0.wdata = 4'(d); end
    else begin i1.req = r; i1.we = we; i1.addr = 3'(a); i1.wdata = 4'(d); end
  endtask

  // cnt operations from client c, req held between them; returns at the last gnt cycle
  task automatic seq(input int c, input bit we, input int a0, input int d0, input int cnt,
                     input int astep, input int dstep);
    for (int i = 0; i < cnt; i++) begin
      int k;
      if (i == 0) begin @(negedge clk); drive(c, 1, we, a0, d0); end
      k = 0;
      do begin @(negedge clk); k++; end while (k < 20 && !g(c));
      if (!g(c)) begin
        checks++;
        errors++;
        $display("FAIL grant_timeout client %0d op %0d: no gnt within 20 cycles", c, i);
        drive(c, 0, we, a0, d0);
        return;
      end
      if (i == cnt - 1) drive(c, 0, we, a0, d0);
      else drive(c, 1, we, a0 + (i + 1) * astep, d0 + (i + 1) * dstep);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    gq = {}; gn = {};
    seq(0, 1, 0, 0, 8, 1, 1);
    repeat (2) @(negedge clk);
    chk("wr_count", 8'(gn.size()), 8'd8);
    if (gn.size() == 8) chk("wr_span", 8'(gn[7] - gn[0]), 8'd14);
    rq1 = {};
    seq(1, 0, 0, 0, 8, 1, 0);
    repeat (2) @(negedge clk);
    chk("rd_count", 8'(rq1.size()), 8'd8);
    for (int i = 0; i < rq1.size(); i++) chk("rd_seq", 8'(rq1[i]), 8'(i));
    chk("rd_c0_silent", 8'(rq0.size()), 8'd0);
    gq = {}; rq1 = {};
    fork
      seq(0, 1, 2, 9, 3, 0, 0);
      seq(1, 0, 2, 0, 3, 0, 0);
    join
    repeat (2) @(negedge clk);
    chk("tie_count", 8'(gq.size()), 8'd6);
    for (int i = 0; i < gq.size(); i++) chk("tie_order", 8'(gq[i]), 8'(i % 2));
    if (rq1.size() > 0) chk("tie_rd", 8'(rq1[0]), 8'd9);
    gq = {}; gn = {};
    seq(0, 1, 4, 3, 3, 1, 1);
    repeat (2) @(negedge clk);
    chk("solo_count", 8'(gn.size()), 8'd3);
    if (gn.size() == 3) begin
      chk("solo_gap1", 8'(gn[1] - gn[0]), 8'd2);
      chk("solo_gap2", 8'(gn[2] - gn[1]), 8'd2);
    end
    rq1 = {};
    seq(0, 1, 5, 12, 1, 0, 0);
    seq(1, 0, 5, 0, 1, 0, 0);
    repeat (2) @(negedge clk);
    if (rq1.size() > 0) chk("raw_rd", 8'(rq1[rq1.size()-1]), 8'd12);
    seq(0, 1, 3, 7, 1, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_gnt", 8'({i0.gnt, i1.gnt}), 8'd0);
    chk("rst_rvalid", 8'({i0.rvalid, i1.rvalid}), 8'd0);
    rst = 1'b0;
    rq1 = {};
    seq(1, 0, 3, 0, 1, 0, 0);
    repeat (2) @(negedge clk);
    if (rq1.size() > 0) chk("rst_commit", 8'(rq1[rq1.size()-1]), 8'd7);
    chk("rdata1_before_rst", 8'(i1.rdata), 8'd7);
    seq(0, 0, 3, 0, 1, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rv0", 8'(i0.rvalid), 8'd0);
    chk("rst_rd0", 8'(i0.rdata), 8'd0);
    chk("rst_rd1", 8'(i1.rdata), 8'd0);
    rst = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 59) == 0);
      for (int c = 0; c < 2; c++) begin
        bit r;
        r = (c == 0) ? i0.req : i1.req;
        if (r && g(c))
          drive(c, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
        else if (!r && $urandom_range(0, 2) == 0)
          drive(c, 1, $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                int'($urandom_range(0, 15)));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
